// File: rtl/rx_packet.sv
// rx_packet: decodes hex-encoded UART integration packets into header fields, payload and timestamp
// Ports:
//   sysclk, reset (async active-low)      clock and reset
//   RXREG[7:0], RXIF                       received byte and its one-cycle valid strobe
//   payload, timestamp                     payload and footer of the last good packet
//   tick, flags, lag_cross, lag_auto,
//   delay_size, num_inputs, resolution     decoded header fields of the last good packet
//   packet_valid, packet_error             one-cycle result pulses
//   error_code                             0 SHORT, 1 LONG, 2 BADCHAR, 3 MISMATCH
//   packet_count                           good packet count, wraps
module rx_packet #(
    parameter int PAYLOAD_SIZE = 1920,
    parameter int NUM_INPUTS   = 8,
    parameter int RESOLUTION   = 24,
    parameter int HEADER_SIZE  = 64,
    parameter int FOOTER_SIZE  = 64
) (
    input  logic                    sysclk,
    input  logic                    reset,
    input  logic [7:0]              RXREG,
    input  logic                    RXIF,
    output logic [PAYLOAD_SIZE-1:0] payload,
    output logic [63:0]             timestamp,
    output logic [15:0]             tick,
    output logic [3:0]              flags,
    output logic [7:0]              lag_cross,
    output logic [7:0]              lag_auto,
    output logic [11:0]             delay_size,
    output logic [7:0]              num_inputs,
    output logic [7:0]              resolution,
    output logic                    packet_valid,
    output logic                    packet_error,
    output logic [1:0]              error_code,
    output logic [15:0]             packet_count
);
    localparam int PACKET_SIZE   = HEADER_SIZE + PAYLOAD_SIZE + FOOTER_SIZE;
    localparam int TOTAL_NIBBLES = PACKET_SIZE / 4;
    localparam int CW            = $clog2(TOTAL_NIBBLES + 1);
    localparam logic [CW-1:0] TN = CW'(TOTAL_NIBBLES);

    typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx, base_cnt;
    logic [PACKET_SIZE-1:0] sr, sr_nx;
    logic [63:0]            hdr;
    logic [3:0]             nib;
    logic [1:0]             code_nx;
    logic                   is_dig, is_hex, is_cr, rx, hdr_ok, ok, err_nx;

    assign is_dig = RXREG >= 8'h30 && RXREG <= 8'h39;
    assign is_hex = is_dig || (RXREG >= 8'h41 && RXREG <= 8'h46) || (RXREG >= 8'h61 && RXREG <= 8'h66);
    assign is_cr  = RXREG == 8'h0D;
    assign rx     = RXIF && RXREG != 8'h0A;
    // letters of either case carry value low-nibble + 9
    assign nib    = is_dig ? RXREG[3:0] : RXREG[3:0] + 4'd9;
    assign hdr    = sr[PACKET_SIZE-1 -: 64];
    assign hdr_ok = hdr[63:56] == 8'(RESOLUTION) && hdr[55:48] == 8'(NUM_INPUTS - 1);
    // a byte arriving during CHECK starts the next frame from count 0
    assign base_cnt = (state == CHECK) ? '0 : cnt;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        sr_nx    = sr;
        ok       = 1'b0;
        err_nx   = 1'b0;
        code_nx  = error_code;
        if (state == CHECK) begin
            state_nx = COLLECT;
            cnt_nx   = '0;
            ok       = hdr_ok;
            err_nx   = !hdr_ok;
            code_nx  = hdr_ok ? error_code : 2'd3;
        end
        // a byte error landing in the cycle after CHECK would collide with the
        // CHECK result pulse, so the CHECK result takes that reporting slot
        if (rx && state == HUNT) begin
            state_nx = is_cr ? COLLECT : HUNT;
            cnt_nx   = '0;
        end else if (rx && is_hex && base_cnt < TN) begin
            sr_nx    = {sr[PACKET_SIZE-5:0], nib};
            cnt_nx   = base_cnt + CW'(1);
            state_nx = COLLECT;
        end else if (rx && is_hex) begin
            state_nx = HUNT;
            err_nx   = 1'b1;
            code_nx  = 2'd1;
        end else if (rx && is_cr && base_cnt == TN) begin
            state_nx = CHECK;
        end else if (rx && is_cr) begin
            state_nx = COLLECT;
            cnt_nx   = '0;
            err_nx   = err_nx || state != CHECK;
            code_nx  = (state != CHECK) ? 2'd0 : code_nx;
        end else if (rx) begin
            state_nx = HUNT;
            err_nx   = err_nx || state != CHECK;
            code_nx  = (state != CHECK) ? 2'd2 : code_nx;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state        <= HUNT;
            cnt          <= '0;
            sr           <= '0;
            payload      <= '0;
            timestamp    <= '0;
            tick         <= '0;
            flags        <= '0;
            lag_cross    <= '0;
            lag_auto     <= '0;
            delay_size   <= '0;
            num_inputs   <= '0;
            resolution   <= '0;
            packet_valid <= 1'b0;
            packet_error <= 1'b0;
            error_code   <= '0;
            packet_count <= '0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            sr           <= sr_nx;
            packet_valid <= ok;
            packet_error <= err_nx;
            error_code   <= code_nx;
            if (ok) begin
                payload      <= sr[64 +: PAYLOAD_SIZE];
                timestamp    <= sr[0 +: 64];
                tick         <= hdr[15:0];
                flags        <= hdr[19:16];
                lag_cross    <= hdr[27:20];
                lag_auto     <= hdr[35:28];
                delay_size   <= hdr[47:36];
                num_inputs   <= hdr[55:48];
                resolution   <= hdr[63:56];
                packet_count <= packet_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_rx_packet.sv
// tb_rx_packet: scoreboard bench for rx_packet with a frame-level reference model
module tb_rx_packet;
    logic         sysclk = 1'b0;
    logic         reset;
    logic [7:0]   RXREG;
    logic         RXIF;
    logic [23:0]  payload;
    logic [63:0]  timestamp;
    logic [15:0]  tick;
    logic [3:0]   flags;
    logic [7:0]   lag_cross, lag_auto, num_inputs, resolution;
    logic [11:0]  delay_size;
    logic         packet_valid, packet_error;
    logic [1:0]   error_code;
    logic [15:0]  packet_count;

    rx_packet #(.PAYLOAD_SIZE(24), .NUM_INPUTS(1), .RESOLUTION(24)) dut (
        .sysclk(sysclk), .reset(reset), .RXREG(RXREG), .RXIF(RXIF),
        .payload(payload), .timestamp(timestamp), .tick(tick), .flags(flags),
        .lag_cross(lag_cross), .lag_auto(lag_auto), .delay_size(delay_size),
        .num_inputs(num_inputs), .resolution(resolution),
        .packet_valid(packet_valid), .packet_error(packet_error),
        .error_code(error_code), .packet_count(packet_count)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        int           at;
        bit           valid;
        logic [1:0]   code;
        logic [151:0] frame;
    } exp_t;

    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    bit           synced = 0;
    logic [3:0]   nibs[$];
    logic [151:0] lg = '0;
    int           lg_cnt = 0;

    localparam logic [151:0] GOLD = {64'h1800_0000_0000_0271, 24'hABCDEF, 64'h0123456789ABCDEF};

    initial forever begin
        @(posedge sysclk);
        cyc++;
    end

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // reference model: one call per byte presented, at the edge cyc+1
    task automatic model(input logic [7:0] b);
        logic [151:0] f;
        exp_t e;
        if (b == 8'h0A) return;
        if (!synced) begin
            if (b == 8'h0D) begin
                synced = 1;
                nibs.delete();
            end
            return;
        end
        e.frame = '0;
        e.valid = 0;
        e.at    = cyc + 1;
        if ((b >= "0" && b <= "9") || (b >= "A" && b <= "F") || (b >= "a" && b <= "f")) begin
            if (nibs.size() < 38) begin
                nibs.push_back(b <= "9" ? 4'(b - "0") : 4'((b | 8'h20) - "a" + 10));
                return;
            end
            synced = 0;
            e.code = 2'd1;
        end else if (b == 8'h0D) begin
            if (nibs.size() == 38) begin
                f = '0;
                foreach (nibs[i]) f = {f[147:0], nibs[i]};
                e.at    = cyc + 2;
                e.frame = f;
                e.valid = f[151:144] == 8'd24 && f[143:136] == 8'd0;
                e.code  = 2'd3;
            end else begin
                e.code = 2'd0;
            end
            nibs.delete();
        end else begin
            synced = 0;
            e.code = 2'd2;
        end
        sb.push_back(e);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge sysclk);
        RXIF  = 1'b1;
        RXREG = b;
        model(b);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge sysclk);
            RXIF = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [151:0] f, input bit lower, input bit lf, input int ndig, input bit cr);
        logic [3:0] n;
        for (int i = 0; i < ndig; i++) begin
            n = (i < 38) ? f[(37 - i) * 4 +: 4] : 4'd0;
            send(n < 10 ? 8'h30 + 8'(n) : (lower ? 8'h61 : 8'h41) + 8'(n) - 8'd10);
            if (lf && i < ndig - 1 && $urandom_range(0, 3) == 0) send(8'h0A);
        end
        if (cr) send(8'h0D);
    endtask

    task automatic cmp_fields();
        chk("payload", 64'(payload), 64'(lg[87:64]));
        chk("timestamp", timestamp, lg[63:0]);
        chk("tick", 64'(tick), 64'(lg[103:88]));
        chk("flags", 64'(flags), 64'(lg[107:104]));
        chk("lag_cross", 64'(lag_cross), 64'(lg[115:108]));
        chk("lag_auto", 64'(lag_auto), 64'(lg[123:116]));
        chk("delay_size", 64'(delay_size), 64'(lg[135:124]));
        chk("num_inputs", 64'(num_inputs), 64'(lg[143:136]));
        chk("resolution", 64'(resolution), 64'(lg[151:144]));
        chk("packet_count", 64'(packet_count), 64'(16'(lg_cnt)));
    endtask

    // monitor: pops the scoreboard whenever the DUT pulses a result
    initial forever begin
        exp_t e;
        @(negedge sysclk);
        if (!reset) begin
            lg     = '0;
            lg_cnt = 0;
        end else if (packet_valid || packet_error) begin
            chk("pulse_exclusive", 64'(packet_valid & packet_error), 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", 64'({packet_valid, packet_error}), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("pulse_cycle", 64'(cyc), 64'(e.at));
                chk("pulse_kind", 64'(packet_valid), 64'(e.valid));
                if (e.valid) begin
                    lg = e.frame;
                    lg_cnt++;
                end else begin
                    chk("error_code", 64'(error_code), 64'(e.code));
                end
                cmp_fields();
            end
        end else if (sb.size() > 0 && cyc > sb[0].at) begin
            chk("missing_pulse", 64'(cyc), 64'(sb[0].at));
            void'(sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [151:0] f;
        int           r, nd, c0;
        logic [7:0]   res, num;
        reset = 1'b0;
        RXIF  = 1'b0;
        RXREG = 8'h00;
        repeat (3) @(negedge sysclk);
        chk("rst_payload", 64'(payload), 64'd0);
        chk("rst_timestamp", timestamp, 64'd0);
        chk("rst_tick", 64'(tick), 64'd0);
        chk("rst_count", 64'(packet_count), 64'd0);
        chk("rst_pulses", 64'({packet_valid, packet_error, error_code}), 64'd0);
        reset = 1'b1;
        // sync and good frame
        send("Z");
        send("Z");
        send(8'h0D);
        send_frame(GOLD, 0, 0, 38, 1);
        idle(3);
        chk("gold_tick", 64'(tick), 64'h0271);
        chk("gold_resolution", 64'(resolution), 64'h18);
        chk("gold_num_inputs", 64'(num_inputs), 64'h00);
        chk("gold_payload", 64'(payload), 64'hABCDEF);
        chk("gold_timestamp", timestamp, 64'h0123456789ABCDEF);
        chk("gold_count", 64'(packet_count), 64'd1);
        // short then good, long then resync
        send_frame(GOLD, 0, 0, 37, 1);
        idle(2);
        send_frame({GOLD[151:64], 64'h1111}, 0, 0, 38, 1);
        idle(2);
        send_frame(GOLD, 0, 0, 39, 0);
        idle(2);
        send_frame({GOLD[151:64], 64'h2222}, 0, 0, 38, 1);
        idle(2);
        send_frame({GOLD[151:64], 64'h3333}, 0, 0, 38, 1);
        idle(2);
        // bad character, then LF-laced frame
        send_frame(GOLD, 0, 0, 10, 0);
        send("G");
        idle(2);
        send(8'h0D);
        send_frame({GOLD[151:88], 24'h123456, 64'h4444}, 0, 1, 38, 1);
        idle(2);
        // header mismatch, then lowercase
        send_frame({8'h10, GOLD[143:0]}, 0, 0, 38, 1);
        idle(2);
        send_frame(GOLD, 1, 0, 38, 1);
        idle(2);
        // back-to-back
        c0 = int'(packet_count);
        send_frame({GOLD[151:64], 64'h5555}, 0, 0, 38, 1);
        send_frame({GOLD[151:64], 64'h6666}, 0, 0, 38, 1);
        idle(3);
        chk("b2b_count", 64'(packet_count), 64'(16'(c0 + 2)));
        // reset mid-frame
        send_frame(GOLD, 0, 0, 20, 0);
        @(negedge sysclk);
        #1;
        reset = 1'b0;
        RXIF  = 1'b0;
        synced = 0;
        nibs.delete();
        sb.delete();
        #1;
        chk("mid_rst_payload", 64'(payload), 64'd0);
        chk("mid_rst_timestamp", timestamp, 64'd0);
        chk("mid_rst_tick", 64'(tick), 64'd0);
        chk("mid_rst_count", 64'(packet_count), 64'd0);
        chk("mid_rst_code", 64'(error_code), 64'd0);
        idle(2);
        reset = 1'b1;
        send_frame(GOLD, 0, 0, 38, 1);
        idle(2);
        send_frame(GOLD, 0, 0, 38, 1);
        idle(3);
        chk("post_rst_count", 64'(packet_count), 64'd1);
        // randomized frames
        for (int k = 0; k < 30; k++) begin
            r   = int'($urandom_range(0, 9));
            res = (r == 0) ? 8'($urandom_range(0, 255)) : 8'h18;
            num = (r == 1) ? 8'($urandom_range(1, 255)) : 8'h00;
            nd  = (r == 2) ? int'($urandom_range(1, 37)) : 38;
            f   = {res, num, 16'($urandom), $urandom, 24'($urandom), $urandom, $urandom};
            send_frame(f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), nd, 1);
            idle(int'($urandom_range(1, 3)));
        end
        idle(10);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
